// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: controller states, default MISR width and feedback polynomial.
package lbist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MISR_WIDTH_DEFAULT = 65;

  // x^65 + x^18 + 1 (primitive trinomial): taps on bits 0 and 18 of the right-shifting register
  localparam logic [64:0] MISR_POLY_DEFAULT = 65'h0_0000_0000_0004_0001;

endpackage

// File: rtl/misr_core.sv
// MISR signature register: Fibonacci feedback, right shift, one response folded per enable.
module misr_core
  import lbist_pkg::*;
#(
  parameter int               WIDTH = MISR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY_DEFAULT),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_sig_next,
  output logic [WIDTH-1:0] o_sig
);

  logic [WIDTH-1:0] r_sig;
  logic             w_fb;

  assign w_fb = ^(r_sig & POLY);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign o_sig_next[gi] = r_sig[gi+1] ^ i_d[gi];
    end
  endgenerate
  assign o_sig_next[WIDTH-1] = w_fb ^ i_d[WIDTH-1];

  // Load takes priority so a session restart never folds in a stray beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_sig <= SEED;
    else if (i_load) r_sig <= i_load_val;
    else if (i_en)   r_sig <= o_sig_next;
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/misr_compactor.sv
// LBIST response compactor: MISR plus IDLE/RUN/DONE run controller and golden compare.
// Optional build macro MISR_XMASK_EN adds i_x_mask to zero X-source response bits.
module misr_compactor
  import lbist_pkg::*;
#(
  parameter int               WIDTH      = MISR_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(MISR_POLY_DEFAULT),
  parameter logic [WIDTH-1:0] SEED       = '0,
  parameter int               N_PATTERNS = 1024,
  parameter logic [WIDTH-1:0] GOLDEN     = '0,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_resp_valid,
  input  logic [WIDTH-1:0] i_resp_data,
`ifdef MISR_XMASK_EN
  input  logic [WIDTH-1:0] i_x_mask,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [WIDTH-1:0] o_signature,
  output logic [CNT_W-1:0] o_pat_count
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_pat_count;
  logic             r_pass;
  logic             w_start_ok;
  logic             w_beat;
  logic             w_last;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_sig_next;

`ifdef MISR_XMASK_EN
  assign w_d = i_resp_data & ~i_x_mask;
`else
  assign w_d = i_resp_data;
`endif

  assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_beat     = (r_state == RUN) && i_resp_valid;
  assign w_last     = w_beat && (r_pat_count == CNT_W'(N_PATTERNS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_next = RUN;
      RUN:     if (w_last)     w_state_next = DONE;
      DONE:    if (w_start_ok) w_state_next = RUN;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      RUN:     o_busy = 1'b1;
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

  // Counter stops at N_PATTERNS because beats are only honoured in RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat_count <= '0;
      r_pass      <= 1'b0;
    end else begin
      if (w_start_ok)  r_pat_count <= '0;
      else if (w_beat) r_pat_count <= r_pat_count + 1'b1;
      if (w_start_ok)  r_pass <= 1'b0;
      else if (w_last) r_pass <= (w_sig_next == GOLDEN);
    end
  end

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_start_ok),
    .i_load_val (SEED),
    .i_en       (w_beat),
    .i_d        (w_d),
    .o_sig_next (w_sig_next),
    .o_sig      (o_signature)
  );

  assign o_pass      = r_pass;
  assign o_pat_count = r_pat_count;

endmodule

// File: tb/tb_misr_compactor.sv
// Self-checking bench for misr_compactor: 4-bit MISR, scoreboard of expected signatures per beat.
module tb_misr_compactor;

  localparam int         W      = 4;
  localparam logic [3:0] POLY_T = 4'b0011;
  localparam logic [3:0] GOLD_A = 4'h8;
  localparam logic [3:0] GOLD_B = 4'h5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_a, valid_a, start_b, valid_b;
  logic [3:0] data_a, data_b;
  logic [3:0] mask_a;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [3:0] sig_a, sig_b, cnt_a, cnt_b;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] model_sig;
  int         model_cnt;

  always #5 clk = ~clk;

  misr_compactor #(.WIDTH(W), .POLY(POLY_T), .SEED(4'h0), .N_PATTERNS(2),
                   .GOLDEN(GOLD_A), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .i_start(start_a), .i_resp_valid(valid_a),
    .i_resp_data(data_a),
`ifdef MISR_XMASK_EN
    .i_x_mask(mask_a),
`endif
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_signature(sig_a), .o_pat_count(cnt_a)
  );

  misr_compactor #(.WIDTH(W), .POLY(POLY_T), .SEED(4'h0), .N_PATTERNS(1),
                   .GOLDEN(GOLD_B), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .i_start(start_b), .i_resp_valid(valid_b),
    .i_resp_data(data_b),
`ifdef MISR_XMASK_EN
    .i_x_mask(4'h0),
`endif
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_signature(sig_b), .o_pat_count(cnt_b)
  );

  // Reference MISR step written directly from the update equations
  function automatic logic [3:0] misr_step(input logic [3:0] s, input logic [3:0] d);
    logic fb;
    fb = ^(s & POLY_T);
    return {fb ^ d[3], s[3] ^ d[2], s[2] ^ d[1], s[1] ^ d[0]};
  endfunction

  task automatic start_session();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a   = 1'b0;
    model_sig = 4'h0;
    model_cnt = 0;
  endtask

  // Drive one valid beat on DUT A, push the model result, then pop and compare
  task automatic beat_a(input logic [3:0] d, input logic [3:0] m, input string name);
    logic [3:0] exp;
    exp_q.push_back(misr_step(model_sig, d & ~m));
    model_sig = misr_step(model_sig, d & ~m);
    model_cnt++;
    valid_a = 1'b1; data_a = d; mask_a = m;
    @(posedge clk); #1;
    valid_a = 1'b0;
    exp = exp_q.pop_front();
    n_checks++;
    if (sig_a !== exp || cnt_a !== 4'(model_cnt)) begin
      n_errors++;
      $display("FAIL %s: sig=%h cnt=%0d required sig=%h cnt=%0d", name, sig_a, cnt_a, exp, model_cnt);
    end else
      $display("beat %s d=%h m=%h sig=%h cnt=%0d", name, d, m, sig_a, cnt_a);
  endtask

  task automatic check_status(input logic b, input logic dn, input logic p, input string name);
    n_checks++;
    if (busy_a !== b || done_a !== dn || pass_a !== p) begin
      n_errors++;
      $display("FAIL %s: busy/done/pass=%b%b%b required %b%b%b", name, busy_a, done_a, pass_a, b, dn, p);
    end else
      $display("status %s busy=%b done=%b pass=%b", name, busy_a, done_a, pass_a);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_status(1'b0, 1'b0, 1'b0, "reset_status");
    n_checks++;
    if (sig_a !== 4'h0 || cnt_a !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_regs: sig=%h cnt=%0d required sig=0 cnt=0", sig_a, cnt_a);
    end
  endtask

  task automatic test_single_beat();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    valid_b = 1'b1; data_b = 4'h5;
    @(posedge clk); #1;
    valid_b = 1'b0;
    n_checks++;
    if (done_b !== 1'b1 || pass_b !== 1'b1 || sig_b !== 4'h5 || busy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL single_beat: done=%b pass=%b sig=%h busy=%b required 1 1 5 0", done_b, pass_b, sig_b, busy_b);
    end else
      $display("single_beat done=%b pass=%b sig=%h", done_b, pass_b, sig_b);
  endtask

  task automatic test_two_beats();
    start_session();
    beat_a(4'h1, 4'h0, "two_b1");
    check_status(1'b1, 1'b0, 1'b0, "two_mid");
    beat_a(4'h0, 4'h0, "two_b2");
    check_status(1'b0, 1'b1, 1'b1, "two_done_pass");
    start_session();
    beat_a(4'h1, 4'h0, "bad_b1");
    beat_a(4'h2, 4'h0, "bad_b2");
    check_status(1'b0, 1'b1, 1'b0, "two_done_fail");
  endtask

  task automatic test_gaps();
    start_session();
    beat_a(4'h1, 4'h0, "gap_b1");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (busy_a !== 1'b1 || cnt_a !== 4'd1 || sig_a !== 4'h1) begin
        n_errors++;
        $display("FAIL gap_hold: busy=%b cnt=%0d sig=%h required 1 1 1", busy_a, cnt_a, sig_a);
      end else
        $display("gap idle cycle %0d busy=%b cnt=%0d", i, busy_a, cnt_a);
    end
    beat_a(4'h0, 4'h0, "gap_b2");
    check_status(1'b0, 1'b1, 1'b1, "gap_done");
    n_checks++;
    if (sig_a !== GOLD_A) begin
      n_errors++;
      $display("FAIL gap_final: sig=%h required %h", sig_a, GOLD_A);
    end
  endtask

  task automatic test_protocol();
    start_session();
    beat_a(4'h3, 4'h0, "proto_b1");
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1 || cnt_a !== 4'd1 || sig_a !== model_sig) begin
      n_errors++;
      $display("FAIL start_in_run: busy=%b cnt=%0d sig=%h required 1 1 %h", busy_a, cnt_a, sig_a, model_sig);
    end else
      $display("start_in_run ignored sig=%h", sig_a);
    beat_a(4'h9, 4'h0, "proto_b2");
    valid_a = 1'b1; data_a = 4'hF;
    @(posedge clk); #1;
    valid_a = 1'b0;
    n_checks++;
    if (done_a !== 1'b1 || sig_a !== model_sig || cnt_a !== 4'd2) begin
      n_errors++;
      $display("FAIL valid_in_done: done=%b sig=%h cnt=%0d required 1 %h 2", done_a, sig_a, cnt_a, model_sig);
    end else
      $display("valid_in_done ignored sig=%h cnt=%0d", sig_a, cnt_a);
    start_a = 1'b1; valid_a = 1'b1; data_a = 4'h7;
    @(posedge clk); #1;
    start_a = 1'b0; valid_a = 1'b0;
    n_checks++;
    if (busy_a !== 1'b1 || sig_a !== 4'h0 || cnt_a !== 4'd0 || pass_a !== 1'b0) begin
      n_errors++;
      $display("FAIL start_and_valid: busy=%b sig=%h cnt=%0d pass=%b required 1 0 0 0", busy_a, sig_a, cnt_a, pass_a);
    end else
      $display("start_and_valid restart sig=%h cnt=%0d", sig_a, cnt_a);
    model_sig = 4'h0;
    model_cnt = 0;
  endtask

  task automatic test_reset_mid_run();
    beat_a(4'hC, 4'h0, "rst_b1");
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || pass_a !== 1'b0 || sig_a !== 4'h0 || cnt_a !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b pass=%b sig=%h cnt=%0d required 0 0 0 0 0",
               busy_a, done_a, pass_a, sig_a, cnt_a);
    end else
      $display("reset_mid_run cleared immediately");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] m;
    for (int s = 0; s < 6; s++) begin
      start_session();
      for (int b = 0; b < 2; b++) begin
        m = 4'h0;
`ifdef MISR_XMASK_EN
        m = 4'($urandom_range(0, 15));
`endif
        beat_a(4'($urandom_range(0, 15)), m, "rand");
      end
      check_status(1'b0, 1'b1, (model_sig == GOLD_A), "rand_done");
    end
  endtask

`ifdef MISR_XMASK_EN
  task automatic test_xmask();
    start_session();
    beat_a(4'hA, 4'hF, "xm_b1");
    beat_a(4'h6, 4'hF, "xm_b2");
    n_checks++;
    if (sig_a !== 4'h0) begin
      n_errors++;
      $display("FAIL xmask_all: sig=%h required 0", sig_a);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start_a = 1'b0; valid_a = 1'b0; data_a = '0; mask_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    model_sig = '0; model_cnt = 0;
    test_reset();
    test_single_beat();
    test_two_beats();
    test_gaps();
    test_protocol();
    test_reset_mid_run();
    test_random();
`ifdef MISR_XMASK_EN
    test_xmask();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
